// File: rtl/stream_mux_rr_pkg.sv
// mux_pkg: mode encodings and the channel-index width helper shared by the stream mux files
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A single channel still needs one index bit so ports never collapse to zero width
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority search starting just after the last-served channel
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = chan_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    logic [SELW-1:0] idx;

    // Walk the ring from farthest to nearest so the channel right after ptr wins last
    always_comb begin
        grant       = ptr;
        grant_valid = 1'b0;
        idx         = ptr;
        for (int k = N; k >= 1; k--) begin
            idx = SELW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with fixed or round-robin select and a registered output
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int N = 4,
    localparam int SELW = chan_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Padding to the full index range lets an out-of-range sel read a harmless zero
    localparam int NP = 2 ** SELW;

    logic [NP-1:0]       valid_pad;
    logic [NP*WIDTH-1:0] data_pad;
    logic [SELW-1:0]     ptr_q, ptr_d, chan_q, chan_d, rr_grant, grant;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                valid_q, valid_d, rr_gv, grant_valid, load_en;

    assign valid_pad = NP'(in_valid);
    assign data_pad  = (NP * WIDTH)'(in_data);
    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

    rr_arbiter #(.N(N)) u_arb (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant       (rr_grant),
        .grant_valid (rr_gv)
    );

    // Pick this cycle's candidate from the active mode and offer ready only to it
    always_comb begin
        load_en     = !valid_q || out_ready;
        grant       = (mode == MODE_RR) ? rr_grant : sel;
        grant_valid = (mode == MODE_RR) ? rr_gv : ((32'(sel) < N) && valid_pad[sel]);
        in_ready    = (!rst && load_en && grant_valid) ? (N'(1) << grant) : '0;
    end

    // Load on a transfer, empty on a drain with nothing granted, otherwise hold
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            valid_d = grant_valid;
            if (grant_valid) begin
                data_d = data_pad[32'(grant) * WIDTH +: WIDTH];
                chan_d = grant;
                ptr_d  = grant;
            end
        end
    end

    // Output register and round-robin pointer; ptr resets to N-1 so the first search starts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SELW'(N - 1);
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
